// File: rtl/food_timer_pkg.sv
// Shared types and helpers for the multi-channel food timer bank.
package food_timer_pkg;

  // Per-channel life cycle: idle, counting down, finished and awaiting ack.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_e;

  // Duration used when a start request carries a length of zero.
  localparam int DEFAULT_TICKS_C = 2;

  // Channel-select width; a single-channel bank still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/food_timer_chan.sv
// One timer channel: state register, countdown and finish/done flags.
// The start request arriving here has already been validated by the bank.
module food_timer_chan
  import food_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_food,
  input  logic             tick_en_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             pause_i,
  input  logic             cancel_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             finish_o,
  output logic [CNT_W-1:0] remaining_o
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             finish_q, finish_d;

  // Next-state: cancel > start > tick decrement > ack.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    rem_d    = rem_q;
    finish_d = 1'b0;
    if (cancel_i) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (start_i) begin
      state_d = ST_RUN;
      rem_d   = len_i;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (tick_en_i && !pause_i) begin
            if (rem_q > CNT_W'(1)) begin
              rem_d = rem_q - CNT_W'(1);
            end else begin
              // Last tick: never decrement below zero, report completion.
              rem_d    = '0;
              state_d  = ST_DONE;
              finish_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ack_i) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, count and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_food) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      finish_q <= finish_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign finish_o    = finish_q;
  assign remaining_o = rem_q;

endmodule

// File: rtl/food_timer_bank.sv
// Bank of independent countdown timers: start decode and validation,
// start_err register and remaining-count readback mux.
module food_timer_bank
  import food_timer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_TICKS = DEFAULT_TICKS_C,
  parameter int CH_W          = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_food,
  input  logic                tick_en,
  input  logic                start,
  input  logic [CH_W-1:0]     start_ch,
  input  logic [CNT_W-1:0]    start_len,
  input  logic [CHANNELS-1:0] pause,
  input  logic [CHANNELS-1:0] cancel,
  input  logic [CHANNELS-1:0] ack,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] finish,
  output logic                start_err,
  output logic [CNT_W-1:0]    rd_remaining
);

  logic                ch_valid;
  logic                cancel_hit;
  logic [CNT_W-1:0]    load_len;
  logic [CHANNELS-1:0] start_vec;
  logic                start_err_q, start_err_d;
  logic [CNT_W-1:0]    rem_arr [CHANNELS];

  assign ch_valid   = (int'(start_ch) < CHANNELS);
  assign cancel_hit = ch_valid && cancel[start_ch];
  assign load_len   = (start_len == '0) ? CNT_W'(DEFAULT_TICKS) : start_len;

  // A start into a running or non-existent channel is rejected; a same-edge
  // cancel silently wins over the start.
  assign start_err_d = start && !cancel_hit && (!ch_valid || busy[start_ch]);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // Channels in IDLE or DONE accept the load; cancel priority lives inside the channel.
    assign start_vec[i] = start && ch_valid && (start_ch == CH_W'(i)) && !busy[i];

    food_timer_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst_food    (rst_food),
      .tick_en_i   (tick_en),
      .start_i     (start_vec[i]),
      .len_i       (load_len),
      .pause_i     (pause[i]),
      .cancel_i    (cancel[i]),
      .ack_i       (ack[i]),
      .busy_o      (busy[i]),
      .done_o      (done[i]),
      .finish_o    (finish[i]),
      .remaining_o (rem_arr[i])
    );
  end

  // One-cycle rejection pulse.
  always_ff @(posedge clk) begin
    if (rst_food) start_err_q <= 1'b0;
    else          start_err_q <= start_err_d;
  end

  assign start_err = start_err_q;

  // Readback of the selected channel's count; out-of-range selects read zero.
  always_comb begin
    rd_remaining = '0;
    if (int'(rd_ch) < CHANNELS) rd_remaining = rem_arr[rd_ch];
  end

endmodule

// File: tb/tb_food_timer_bank.sv
// Self-checking bench for food_timer_bank: directed scenarios followed by a
// randomized phase, all compared against a behavioural channel model.
module tb_food_timer_bank;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_food, tick_en, start;
  logic [1:0]    start_ch, rd_ch;
  logic [CW-1:0] start_len;
  logic [N-1:0]  pause, cancel, ack;
  logic [N-1:0]  busy, done, finish;
  logic          start_err;
  logic [CW-1:0] rd_remaining;

  // Three-channel instance: the only way to present an out-of-range channel
  // number, since a 2-bit select cannot encode a value of 4 or above.
  logic          s3_start;
  logic [1:0]    s3_ch, s3_rd;
  logic [2:0]    s3_zero = '0;
  logic [2:0]    s3_busy, s3_done, s3_fin;
  logic          s3_err;
  logic [CW-1:0] s3_rem;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_fin [N];
  int t0, t1, t2;

  // Behavioural model of each channel.
  bit m_run  [N];
  bit m_done [N];
  bit m_fin  [N];
  int m_rem  [N];
  bit m_err;

  always #5 clk = ~clk;

  food_timer_bank #(.CHANNELS(N), .CNT_W(CW), .DEFAULT_TICKS(2)) u_dut (
    .clk(clk), .rst_food(rst_food), .tick_en(tick_en), .start(start),
    .start_ch(start_ch), .start_len(start_len), .pause(pause),
    .cancel(cancel), .ack(ack), .rd_ch(rd_ch), .busy(busy), .done(done),
    .finish(finish), .start_err(start_err), .rd_remaining(rd_remaining)
  );

  food_timer_bank #(.CHANNELS(3), .CNT_W(CW), .DEFAULT_TICKS(2)) u_dut3 (
    .clk(clk), .rst_food(rst_food), .tick_en(tick_en), .start(s3_start),
    .start_ch(s3_ch), .start_len(8'd7), .pause(s3_zero),
    .cancel(s3_zero), .ack(s3_zero), .rd_ch(s3_rd), .busy(s3_busy),
    .done(s3_done), .finish(s3_fin), .start_err(s3_err),
    .rd_remaining(s3_rem)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply the timer rules to the model for one clock edge.
  task automatic model_edge();
    int  ch;
    bit  in_rng;
    if (rst_food) begin
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_done[i] = 0; m_fin[i] = 0; m_rem[i] = 0;
      end
      m_err = 0;
      return;
    end
    ch     = int'(start_ch);
    in_rng = (ch < N);
    m_err  = start && !(in_rng && cancel[ch]) && (!in_rng || m_run[ch]);
    for (int i = 0; i < N; i++) begin
      m_fin[i] = 0;
      if (cancel[i]) begin
        m_run[i] = 0; m_done[i] = 0; m_rem[i] = 0;
      end else if (start && ch == i && !m_run[i]) begin
        m_run[i]  = 1;
        m_done[i] = 0;
        m_rem[i]  = (start_len == 0) ? 2 : int'(start_len);
      end else if (m_run[i] && tick_en && !pause[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_run[i] = 0; m_done[i] = 1; m_fin[i] = 1;
        end
      end else if (m_done[i] && ack[i]) begin
        m_done[i] = 0;
      end
    end
  endtask

  // One clock edge: update the model, then compare all outputs after the edge.
  task automatic step();
    logic [N-1:0] eb, ed, ef;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      eb[i] = m_run[i]; ed[i] = m_done[i]; ef[i] = m_fin[i];
      if (finish[i] === 1'b1) last_fin[i] = cyc;
    end
    check("busy",         32'(busy),         32'(eb));
    check("done",         32'(done),         32'(ed));
    check("finish",       32'(finish),       32'(ef));
    check("start_err",    32'(start_err),    32'(m_err));
    check("rd_remaining", 32'(rd_remaining), m_rem[rd_ch]);
  endtask

  task automatic idle_inputs();
    start = 0; start_ch = 0; start_len = 0;
    pause = 0; cancel = 0; ack = 0;
  endtask

  task automatic clear_fin();
    for (int i = 0; i < N; i++) last_fin[i] = -1;
  endtask

  initial begin
    rst_food = 1; tick_en = 0; rd_ch = 0;
    s3_start = 0; s3_ch = 0; s3_rd = 0;
    idle_inputs();
    clear_fin();
    step(); step();
    check("reset_busy", 32'(busy), 32'h0);
    rst_food = 0;

    // Default-length start on ch0.
    start = 1; start_ch = 0; start_len = 0; tick_en = 1; rd_ch = 0;
    step(); t0 = cyc; start = 0;
    repeat (4) step();
    check("default_latency", 32'(last_fin[0] - t0), 32'd2);
    check("done0_sticky", 32'(done[0]), 32'd1);
    ack = 4'b0001; step(); ack = 0;
    check("done0_acked", 32'(done[0]), 32'd0);

    // ch1 len 5 then ch2 len 3, tick on every second edge.
    clear_fin(); rd_ch = 1; tick_en = 0;
    start = 1; start_ch = 1; start_len = 5;
    step(); t1 = cyc;
    for (int k = 1; k <= 12; k++) begin
      tick_en = (k % 2 == 0);
      if (k == 1) begin start = 1; start_ch = 2; start_len = 3; end
      else start = 0;
      step();
      if (k == 1) t2 = cyc;
    end
    check("ch1_latency", 32'(last_fin[1] - t1), 32'd10);
    check("ch2_latency", 32'(last_fin[2] - t2), 32'd5);

    // ch0 len 4 with a 3-cycle pause.
    ack = 4'hF; tick_en = 0; step(); ack = 0;
    clear_fin(); rd_ch = 0; tick_en = 1;
    start = 1; start_ch = 0; start_len = 4;
    step(); t0 = cyc; start = 0;
    for (int k = 1; k <= 9; k++) begin
      pause[0] = (k >= 2 && k <= 4);
      step();
    end
    pause = 0;
    check("pause_latency", 32'(last_fin[0] - t0), 32'd7);

    // Restart of a running channel is rejected.
    tick_en = 0; rd_ch = 3;
    start = 1; start_ch = 3; start_len = 6; step();
    start = 1; start_ch = 3; start_len = 2; step();
    check("restart_err", 32'(start_err), 32'd1);
    check("restart_keep", 32'(rd_remaining), 32'd6);
    start = 0; step();
    check("err_one_cycle", 32'(start_err), 32'd0);

    // Cancel beats start on the same channel.
    start = 1; start_ch = 1; start_len = 4; cancel = 4'b0010; step();
    start = 0; cancel = 0;
    check("cancel_busy1", 32'(busy[1]), 32'd0);
    check("cancel_no_err", 32'(start_err), 32'd0);

    // Ack on the completion edge loses to completion.
    start = 1; start_ch = 2; start_len = 1; step(); start = 0;
    tick_en = 1; ack = 4'b0100; step(); ack = 0;
    check("ack_vs_finish_done", 32'(done[2]), 32'd1);
    check("ack_vs_finish_pulse", 32'(finish[2]), 32'd1);

    // Reset while ch0 is on its last tick.
    cancel = 4'hF; step(); cancel = 0;
    rd_ch = 0; start = 1; start_ch = 0; start_len = 3; step(); start = 0;
    step(); step();
    check("rem_before_reset", 32'(rd_remaining), 32'd1);
    rst_food = 1; step(); rst_food = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    step();
    check("rst_no_finish", 32'(finish), 32'd0);

    // Out-of-range channel on the three-channel instance.
    tick_en = 0;
    s3_start = 1; s3_ch = 3; step(); s3_start = 0;
    check("oor_start_err", 32'(s3_err), 32'd1);
    check("oor_no_busy", 32'(s3_busy), 32'd0);
    s3_rd = 3; step();
    check("oor_err_clear", 32'(s3_err), 32'd0);
    check("oor_rd_zero", 32'(s3_rem), 32'd0);
    s3_start = 1; s3_ch = 2; step(); s3_start = 0; s3_rd = 2;
    #1;
    check("s3_rd_ch2", 32'(s3_rem), 32'd7);
    check("s3_busy_ch2", 32'(s3_busy), 32'b100);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst_food  = ($urandom_range(0, 99) == 0);
      tick_en   = $urandom_range(0, 1);
      start     = ($urandom_range(0, 2) == 0);
      start_ch  = 2'($urandom_range(0, 3));
      start_len = 8'($urandom_range(0, 7));
      rd_ch     = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        pause[i]  = ($urandom_range(0, 3) == 0);
        cancel[i] = ($urandom_range(0, 15) == 0);
        ack[i]    = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
